// File: rtl/bias_relu_stage.sv
// ---------------------------------------------------------------------------
// bias_relu_stage
//   Element-serial bias add plus optional ReLU sitting behind the matmul
//   stage. One shared add_float computes x[k] + bias[k] for k = 0..N-1. Each
//   result is written into its own slot of the output vector.
//
//   Ports (top):
//     clk       clock, rising edge
//     rst       asynchronous, active-high reset
//     start     one-cycle pulse: latch x/bias and begin a run (ignored when busy)
//     x, bias   S*N flattened vectors, element k at [S*(k+1)-1:S*k]
//     o         registered result vector, same layout
//     busy      high while a run is in progress
//     done      level, high after the last element is written until the
//               next accepted start or reset
//     nan_flag  sticky OR of adder NaN results over the current run
//     ovf_flag  sticky OR of adder overflow over the current run
//
//   add_float (helper, same file)
//     Two-cycle IEEE-754 adder with round-to-nearest-even. Operands are
//     latched on start and the result, done, nan and overflow are registered
//     one cycle later. done is a one-cycle pulse. rst_n is asynchronous and
//     active-low.
// ---------------------------------------------------------------------------

module add_float #(
    parameter int S = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         sub,
    output logic [S-1:0] y,
    output logic         done,
    output logic         nan,
    output logic         overflow
);
    localparam int EW = (S == 64) ? 11 : (S == 16) ? 5 : 8;
    localparam int MW = S - EW - 1;
    localparam int M  = MW + 1;     // significand including hidden bit
    localparam int XW = M + 3;      // plus guard, round, sticky
    localparam logic [EW-1:0] EMAX = '1;

    logic [S-1:0] a_q, b_q;
    logic         busy_q;

    logic [S-1:0] res;
    logic         res_nan, res_ovf;

    function automatic int lzc(input logic [XW-1:0] v);
        int  n;
        bit  found;
        n = 0;
        found = 1'b0;
        for (int i = XW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n++;
            end
        end
        return n;
    endfunction

    logic          sa, sb, s_big, eff_sub, swap, sticky, rnd_up;
    logic          a_nan, b_nan, a_inf, b_inf;
    logic [EW-1:0] ea, eb, e_big, e_small, eb_eff, es_eff;
    logic [MW-1:0] fa, fb, f_big, f_small;
    logic [XW-1:0] x_big, x_small, al, norm;
    logic [XW:0]   sum;
    logic [M:0]    mr;
    int            dd, ei, lz, sh;

    always_comb begin
        sa = a_q[S-1];  ea = a_q[S-2:MW];  fa = a_q[MW-1:0];
        sb = b_q[S-1];  eb = b_q[S-2:MW];  fb = b_q[MW-1:0];
        a_nan = (ea == EMAX) && (fa != '0);
        b_nan = (eb == EMAX) && (fb != '0);
        a_inf = (ea == EMAX) && (fa == '0);
        b_inf = (eb == EMAX) && (fb == '0);
        eff_sub = sa ^ sb;

        // Larger magnitude goes first so the difference is never negative.
        swap    = {eb, fb} > {ea, fa};
        s_big   = swap ? sb : sa;
        e_big   = swap ? eb : ea;
        f_big   = swap ? fb : fa;
        e_small = swap ? ea : eb;
        f_small = swap ? fa : fb;

        // Subnormals share the exponent of the smallest normal.
        eb_eff = (e_big == '0)   ? EW'(1) : e_big;
        es_eff = (e_small == '0) ? EW'(1) : e_small;
        dd     = int'(eb_eff) - int'(es_eff);

        x_big   = {(e_big != '0), f_big, 3'b000};
        x_small = {(e_small != '0), f_small, 3'b000};
        al      = '0;
        sticky  = 1'b0;
        if (dd >= XW) begin
            sticky = |x_small;
        end else begin
            al     = x_small >> dd;
            sticky = |(x_small & ~({XW{1'b1}} << dd));
        end
        al[0] = al[0] | sticky;

        sum = eff_sub ? ({1'b0, x_big} - {1'b0, al}) : ({1'b0, x_big} + {1'b0, al});

        ei   = int'(eb_eff);
        lz   = 0;
        sh   = 0;
        norm = '0;
        if (sum[XW]) begin
            norm    = sum[XW:1];
            norm[0] = sum[1] | sum[0];
            ei      = ei + 1;
        end else begin
            // Left-normalise, but never below the subnormal exponent.
            lz   = lzc(sum[XW-1:0]);
            sh   = (lz < ei - 1) ? lz : ei - 1;
            norm = sum[XW-1:0] << sh;
            ei   = ei - sh;
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mr     = {1'b0, norm[XW-1:3]} + (M+1)'(rnd_up);
        if (mr[M]) begin
            mr = mr >> 1;
            ei = ei + 1;
        end

        res_nan = 1'b0;
        res_ovf = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            res     = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};
            res_nan = 1'b1;
        end else if (a_inf) begin
            res = {sa, EMAX, {MW{1'b0}}};
        end else if (b_inf) begin
            res = {sb, EMAX, {MW{1'b0}}};
        end else if (sum == '0) begin
            // Exact cancellation gives +0; only -0 + -0 keeps the sign.
            res = {(eff_sub ? 1'b0 : s_big), {(S-1){1'b0}}};
        end else if (ei >= int'(EMAX)) begin
            res     = {s_big, EMAX, {MW{1'b0}}};
            res_ovf = 1'b1;
        end else begin
            // Hidden bit clear after rounding means the result is subnormal.
            res = {s_big, (mr[M-1] ? EW'(ei) : {EW{1'b0}}), mr[MW-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
            y        <= '0;
            done     <= 1'b0;
            nan      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q    <= a;
                b_q    <= sub ? {~b[S-1], b[S-2:0]} : b;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                busy_q   <= 1'b0;
                y        <= res;
                done     <= 1'b1;
                nan      <= res_nan;
                overflow <= res_ovf;
            end
        end
    end
endmodule

module bias_relu_stage #(
    parameter int S   = 32,
    parameter int N   = 4,
    parameter int ACT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [S*N-1:0] x,
    input  logic [S*N-1:0] bias,
    output logic [S*N-1:0] o,
    output logic           busy,
    output logic           done,
    output logic           nan_flag,
    output logic           ovf_flag
);
    localparam int EW = (S == 64) ? 11 : (S == 16) ? 5 : 8;
    localparam int MW = S - EW - 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    logic [1:0]          state;
    logic [N-1:0][S-1:0] x_q, b_q, o_q;
    logic [IW-1:0]       idx;
    logic [S-1:0]        sum_q, add_y;
    logic                add_start, add_done, add_nan, add_ovf, add_rst_n;

    assign o         = o_q;
    assign add_rst_n = ~rst;
    // Decoded from registered state, so the adder cannot answer in ISSUE.
    assign add_start = (state == ISSUE);

    add_float #(.S(S)) u_add (
        .clk      (clk),
        .rst_n    (add_rst_n),
        .start    (add_start),
        .a        (x_q[idx]),
        .b        (b_q[idx]),
        .sub      (1'b0),
        .y        (add_y),
        .done     (add_done),
        .nan      (add_nan),
        .overflow (add_ovf)
    );

    // ReLU keeps NaN payloads visible downstream; any negative (incl. -0,
    // -inf) collapses to +0.
    function automatic logic [S-1:0] act_fn(input logic [S-1:0] v);
        if (ACT == 0)                                   return v;
        if ((&v[S-2:MW]) && (|v[MW-1:0]))               return v;
        if (v[S-1])                                     return '0;
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            x_q      <= '0;
            b_q      <= '0;
            o_q      <= '0;
            idx      <= '0;
            sum_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            nan_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q      <= x;
                        b_q      <= bias;
                        nan_flag <= 1'b0;
                        ovf_flag <= 1'b0;
                        done     <= 1'b0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (add_done) begin
                        sum_q    <= add_y;
                        nan_flag <= nan_flag | add_nan;
                        ovf_flag <= ovf_flag | add_ovf;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    o_q[idx] <= act_fn(sum_q);
                    if (idx == IW'(N - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bias_relu_stage.sv
// ---------------------------------------------------------------------------
// tb_bias_relu_stage
//   Drives two instances (ReLU and linear) from shared inputs. Expected
//   vectors come from literal test vectors or from an integer-valued model:
//   random operands are small integers, so every sum is exact and the float
//   result is the integer sum converted to single precision.
// ---------------------------------------------------------------------------

module tb_bias_relu_stage;
    localparam int S  = 32;
    localparam int N  = 4;
    localparam int W  = S * N;
    localparam int LA = 2;   // adder ISSUE-to-done cycles

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] x, bias, o1, o0;
    logic         busy1, done1, nan1, ovf1;
    logic         busy0, done0, nan0, ovf0;

    always #5 clk = ~clk;

    bias_relu_stage #(.S(S), .N(N), .ACT(1)) d1 (
        .clk(clk), .rst(rst), .start(start), .x(x), .bias(bias),
        .o(o1), .busy(busy1), .done(done1), .nan_flag(nan1), .ovf_flag(ovf1));

    bias_relu_stage #(.S(S), .N(N), .ACT(0)) d0 (
        .clk(clk), .rst(rst), .start(start), .x(x), .bias(bias),
        .o(o0), .busy(busy0), .done(done0), .nan_flag(nan0), .ovf_flag(ovf0));

    int           checks = 0;
    int           errors = 0;
    bit           chk_en = 1'b0;
    logic [W-1:0] exp1, exp0;
    logic         en1, eo1, en0, eo0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, req);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Integer to single-precision bits; exact for |v| < 2^24.
    function automatic logic [31:0] i2f(input int v);
        logic [31:0] m;
        int          msb;
        logic        s;
        if (v == 0) return 32'h0;
        s   = (v < 0);
        m   = s ? 32'(-v) : 32'(v);
        msb = 0;
        for (int i = 0; i < 31; i++) if (m[i]) msb = i;
        m = m << (23 - msb);
        return {s, 8'(127 + msb), m[22:0]};
    endfunction

    function automatic logic [W-1:0] p4(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    // Output vector and sticky flags must hold the model values while done.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (done1) begin
                chk("o_relu", o1, exp1);
                chk_b("nan_relu", nan1, en1);
                chk_b("ovf_relu", ovf1, eo1);
            end
            if (done0) begin
                chk("o_linear", o0, exp0);
                chk_b("nan_linear", nan0, en0);
                chk_b("ovf_linear", ovf0, eo0);
            end
        end
    end

    task automatic run(input logic [W-1:0] xv, bv, e1, e0,
                       input logic n1, v1, n0, v0, input bit glitch, input string nm);
        int cnt;
        chk_en = 1'b0;
        x = xv; bias = bv;
        exp1 = e1; exp0 = e0;
        en1 = n1; eo1 = v1; en0 = n0; eo0 = v0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x = {$urandom, $urandom, $urandom, $urandom};
        bias = {$urandom, $urandom, $urandom, $urandom};
        chk_b({nm, "_busy_on"}, busy1, 1'b1);
        chk_b({nm, "_done_drop"}, done1, 1'b0);
        cnt = 1;
        while (!done1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            start = (glitch && cnt == 3);
        end
        start = 1'b0;
        chk_i({nm, "_latency"}, cnt, 1 + N * (LA + 2));
        chk_b({nm, "_done_lin"}, done0, 1'b1);
        chk_b({nm, "_busy_lin"}, busy0, 1'b0);
        chk_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_b({nm, "_stay_idle"}, busy1, 1'b0);
        chk_b({nm, "_stay_done"}, done1, 1'b1);
    endtask

    task automatic rand_run(input string nm);
        int           xi, bi;
        logic [W-1:0] xv, bv, e1, e0;
        for (int k = 0; k < N; k++) begin
            xi = int'($urandom_range(2000)) - 1000;
            bi = ($urandom_range(3) == 0) ? -xi : int'($urandom_range(2000)) - 1000;
            xv[k*S +: S] = i2f(xi);
            bv[k*S +: S] = i2f(bi);
            e0[k*S +: S] = i2f(xi + bi);
            e1[k*S +: S] = i2f((xi + bi < 0) ? 0 : xi + bi);
        end
        run(xv, bv, e1, e0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nm);
    endtask

    logic [W-1:0] vx, vb, vr, vl;

    initial begin
        rst = 1'b1; start = 1'b0; x = '0; bias = '0;
        exp1 = '0; exp0 = '0; en1 = 0; eo1 = 0; en0 = 0; eo0 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o", o1, '0);
        chk_b("rst_busy", busy1, 1'b0);
        chk_b("rst_done", done1, 1'b0);
        chk_b("rst_nan", nan1, 1'b0);
        chk_b("rst_ovf", ovf1, 1'b0);
        @(negedge clk) rst = 1'b0;

        chk("model_i2f_3", {96'h0, i2f(3)}, {96'h0, 32'h40400000});
        chk("model_i2f_m2", {96'h0, i2f(-2)}, {96'h0, 32'hC0000000});

        vx = p4(32'h3F800000, 32'hC0000000, 32'h3F000000, 32'h00000000);
        vb = p4(32'h3F000000, 32'h3F000000, 32'hBF800000, 32'h00000000);
        vr = p4(32'h3FC00000, 32'h00000000, 32'h00000000, 32'h00000000);
        vl = p4(32'h3FC00000, 32'hBFC00000, 32'hBF000000, 32'h00000000);
        run(vx, vb, vr, vl, 0, 0, 0, 0, 0, "basic");

        run(p4(32'h7FC00000, 32'hC0000000, 32'h3F000000, 32'h0), p4(32'h3F800000, 32'h3F000000, 32'hBF800000, 32'h0),
            p4(32'h7FC00000, 32'h0, 32'h0, 32'h0), p4(32'h7FC00000, 32'hBFC00000, 32'hBF000000, 32'h0),
            1, 0, 1, 0, 0, "nan");

        run(vx, vb, vr, vl, 0, 0, 0, 0, 0, "clean");

        run(p4(32'h3F800000, 32'h7F7FFFFF, 32'h3F000000, 32'h0), p4(32'h3F000000, 32'h7F7FFFFF, 32'hBF800000, 32'h0),
            p4(32'h3FC00000, 32'h7F800000, 32'h0, 32'h0), p4(32'h3FC00000, 32'h7F800000, 32'hBF000000, 32'h0),
            0, 1, 0, 1, 0, "ovf");

        run(vx, vb, vr, vl, 0, 0, 0, 0, 1, "busy_start");

        // Reset while element 2 is waiting on the adder.
        chk_en = 1'b0;
        x = p4(32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000);
        bias = vb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_o_relu", o1, '0);
        chk("midrst_o_lin", o0, '0);
        chk_b("midrst_busy", busy1, 1'b0);
        chk_b("midrst_done", done1, 1'b0);
        @(negedge clk) rst = 1'b0;
        rand_run("after_rst");

        for (int r = 0; r < 20; r++) rand_run($sformatf("rand%0d", r));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bias_relu_stage.md
Name: bias_relu_stage

Overview:
- Downstream neighbour of the matrix-multiply stage in the neural-net datapath.
- Takes the flattened float result vector of a layer's matmul and adds a per-element bias.
- Optionally applies ReLU, then presents the layer output vector for the next layer.
- Element-serial: processes one element at a time through a single shared add_float instance to bound area.

Parameters:
S, 32, float width in bits (IEEE-754 single when 32)
N, 4, number of elements in vector (matmul H*W)
ACT, 1, 1 = apply ReLU after bias add, 0 = bypass (linear output layer)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; latch x and bias, begin processing
x  input  S*N  matmul result vector; element k at bits [S*(k+1)-1:S*k]
bias  input  S*N  bias vector, same layout as x
o  output  S*N  registered result vector, same layout
busy  output  1  high while processing
done  output  1  level; high once all N elements are written, until next accepted start or reset
nan_flag  output  1  sticky OR of adder nan over the current run
ovf_flag  output  1  sticky OR of adder overflow over the current run

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: o=0, busy=0, done=0, nan_flag=0, ovf_flag=0, FSM=IDLE, element index=0.
- Internal add_float reset input is active-low; drive it as the inverse of rst.
- FSM states:
  - IDLE: on start: latch x and bias into internal regs, clear flags, clear done, index=0, busy=1 -> ISSUE.
  - ISSUE (1 cycle): pulse adder start with a=x[index], b=bias[index], sub=0 -> WAIT.
  - WAIT: hold until adder done. Capture sum, OR nan/overflow into sticky flags -> WRITE.
  - WRITE (1 cycle): write processed element to o[index].
    - If index==N-1: busy=0, done=1 -> IDLE.
    - Else index+1 -> ISSUE.
- Element processing in WRITE:
  - ACT=0: o[index]=sum unchanged.
  - ACT=1, sum is NaN (exp all ones, mantissa nonzero): pass through unchanged.
  - ACT=1, sign bit 1 (includes -0 and -inf): write +0 (all zeros).
  - ACT=1, otherwise: pass sum unchanged.
- Latency: with adder latency La (ISSUE-to-done cycles), total from start to done = 1 + N*(La+2) cycles. done rises on the cycle after the last WRITE edge.
- o elements update individually as written. Unwritten elements keep prior values until overwritten. Consumers sample o only while done=1.
- Index counter is clog2(N) bits, minimum 1; no wrap beyond N-1.
- Boundary conditions:
  - start while busy: ignored; latched inputs, index and flags unaffected.
  - start while done=1 (IDLE): accepted; done drops the following cycle.
  - x/bias changing after start: no effect (latched copy used).
  - rst mid-run: immediate return to reset values, including o; adder is reset as well. No partial done.
  - N=1: single ISSUE/WAIT/WRITE pass.
  - Adder done arriving in ISSUE cycle: not possible; adder start is registered.

Test Plan:
- N=4, ACT=1, x={1.0,-2.0,0.5,0} = {3F800000,C0000000,3F000000,00000000}, bias={0.5,0.5,-1.0,0} = {3F000000,3F000000,BF800000,00000000}, start pulse -> o={3FC00000,00000000,00000000,00000000}, done=1 after 1+4*(La+2) cycles, flags 0.
- Same vectors, ACT=0 -> o={3FC00000,BFC00000,BF000000,00000000}.
- ACT=1, x[0]=7FC00000, bias[0]=3F800000 -> o[0]=7FC00000 (NaN passes), nan_flag=1. Next run with clean data -> nan_flag=0.
- x[1]=7F7FFFFF, bias[1]=7F7FFFFF -> ovf_flag=1, o[1]=7F800000 (+inf).
- Pulse start again 3 cycles into a run with different x -> ignored; results match the first vectors; exactly one done assertion.
- Assert rst during WAIT of element 2 -> o=0, busy=0, done=0 same cycle. Fresh start afterwards completes correctly with nominal latency.
